vga_sync: RTL and testbench

Timing generator that drives the pixel-coordinate side of the display pipeline for 640x480 @ 60 Hz VGA. It divides the system clock into a pixel-rate enable and runs horizontal and vertical counters. From those counters it produces `hsync`, `vsync`, `video_on`, `pixel_x` and `pixel_y`. The graphic generator consumes these outputs and returns 12-bit `rgb`; this block only passes that `rgb` through, gated and registered, to the connector pins.

---
 rtl/vga_sync_if.sv | 23 ++
 rtl/vga_sync.sv | 92 +++++++++
 tb/tb_vga_sync.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// Pixel-side bundle between the VGA timing generator and the graphic generator.
// master: timing generator (drives coordinates/syncs, consumes rgb_in).
interface vga_sync_if;
  logic [11:0] rgb_in;
  logic        p_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb_out;
  logic        frame_tick;

  modport master (
    input  rgb_in,
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, rgb_out, frame_tick
  );

  modport slave (
    output rgb_in,
    input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, rgb_out, frame_tick
  );
endinterface

// File: rtl/vga_sync.sv
// 640x480@60 VGA timing generator: pixel-rate enable, h/v counters, registered
// syncs and a blanked, registered colour path to the connector.
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  vga_sync_if.master  bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             p_tick, h_end, v_end, video_on;

  assign p_tick   = (div_q == DIV_LAST);
  assign h_end    = (h_q == H_LAST);
  assign v_end    = (v_q == V_LAST);
  assign video_on = (h_q < H_VIS) && (v_q < V_VIS);

  always_comb begin
    div_d = p_tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (p_tick) begin
      h_d = h_end ? 10'd0 : h_q + 10'd1;
      if (h_end) begin
        v_d = v_end ? 10'd0 : v_q + 10'd1;
      end
    end
    // Syncs decode the next-state counters so they switch with pixel_x/pixel_y.
    hsync_d = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
    vsync_d = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
    rgb_d   = rgb_q;
    if (p_tick) begin
      rgb_d = video_on ? bus.rgb_in : 12'h000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 12'h000;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.p_tick     = p_tick;
  assign bus.pixel_x    = h_q;
  assign bus.pixel_y    = v_q;
  assign bus.video_on   = video_on;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.rgb_out    = rgb_q;
  assign bus.frame_tick = p_tick && h_end && v_end;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default 640x480 instance plus a tiny-parameter instance,
// closed-form timing model feeding per-cycle scoreboards, vector table and corner sequences.
module tb_vga_sync;

  typedef struct packed {
    logic        pt;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        ft;
  } obs_t;

  typedef struct packed {
    int n; int x; int y; int pt; int von; int hs; int vs; int rgb;
  } vec_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n0 = 0, n1 = 0, cyc = 0;
  int   n_checks = 0, n_fail = 0;
  obs_t q0[$], q1[$];
  vec_t tv[13];

  always #5 clk = ~clk;

  vga_sync_if bus0();
  vga_sync_if bus1();

  vga_sync u_dut (.clk(clk), .reset_n(rst0), .bus(bus0));

  vga_sync #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (.clk(clk), .reset_n(rst1), .bus(bus1));

  // Expected outputs after n clk edges since reset release, with constant rgb_in c.
  function automatic obs_t model(int n, int cd, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb, logic [11:0] c);
    obs_t o;
    int ht, vt, p, x, y, px, py;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    p  = n / cd;
    x  = p % ht;
    y  = (p / ht) % vt;
    o.pt  = ((n % cd) == cd - 1);
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.von = (x < hd) && (y < vd);
    o.hs  = !((x >= hd + hf) && (x < hd + hf + hs));
    o.vs  = !((y >= vd + vf) && (y < vd + vf + vs));
    o.rgb = 12'h000;
    if (p > 0) begin
      px = (p - 1) % ht;
      py = ((p - 1) / ht) % vt;
      if ((px < hd) && (py < vd)) o.rgb = c;
    end
    o.ft = o.pt && (x == ht - 1) && (y == vt - 1);
    return o;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst0) n0 = 0; else n0++;
    if (!rst1) n1 = 0; else n1++;
    q0.push_back(model(n0, 4, 640, 16, 96, 48, 480, 10, 2, 33, 12'hFFF));
    q1.push_back(model(n1, 2, 8, 2, 2, 2, 4, 1, 1, 1, 12'hA5C));
  end

  initial forever begin
    obs_t e, a;
    @(negedge clk);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {bus0.p_tick, bus0.pixel_x, bus0.pixel_y, bus0.video_on, bus0.hsync,
           bus0.vsync, bus0.rgb_out, bus0.frame_tick};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL sb_default n=%0d got %h expected %h", n0, a, e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {bus1.p_tick, bus1.pixel_x, bus1.pixel_y, bus1.video_on, bus1.hsync,
           bus1.vsync, bus1.rgb_out, bus1.frame_tick};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL sb_small n=%0d got %h expected %h", n1, a, e);
      end
    end
  end

  task automatic wait_n0(input int target);
    int g;
    g = 0;
    while (n0 < target && g < 30000) begin
      @(negedge clk);
      g++;
    end
    chk("wait_n0", n0, target);
  endtask

  task automatic wait_ft1(output int t);
    int g;
    g = 0;
    while (!bus1.frame_tick && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("frame_tick_seen", int'(bus1.frame_tick), 1);
    t = cyc;
  endtask

  initial begin
    int t1, t2, lo, pt, g;
    //        n     x    y  pt von hs vs rgb
    tv[0]  = '{0,    0,   0, 0, 1, 1, 1, 0};
    tv[1]  = '{3,    0,   0, 1, 1, 1, 1, 0};
    tv[2]  = '{4,    1,   0, 0, 1, 1, 1, 'hFFF};
    tv[3]  = '{2559, 639, 0, 1, 1, 1, 1, 'hFFF};
    tv[4]  = '{2563, 640, 0, 1, 0, 1, 1, 'hFFF};
    tv[5]  = '{2564, 641, 0, 0, 0, 1, 1, 0};
    tv[6]  = '{2623, 655, 0, 1, 0, 1, 1, 0};
    tv[7]  = '{2624, 656, 0, 0, 0, 0, 1, 0};
    tv[8]  = '{3007, 751, 0, 1, 0, 0, 1, 0};
    tv[9]  = '{3008, 752, 0, 0, 0, 1, 1, 0};
    tv[10] = '{3199, 799, 0, 1, 0, 1, 1, 0};
    tv[11] = '{3200, 0,   1, 0, 1, 1, 1, 0};
    tv[12] = '{3204, 1,   1, 0, 1, 1, 1, 'hFFF};

    rst0 = 1'b0;
    rst1 = 1'b0;
    bus0.rgb_in = 12'hFFF;
    bus1.rgb_in = 12'hA5C;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_hsync",    int'(bus0.hsync), 1);
    chk("rst_vsync",    int'(bus0.vsync), 1);
    chk("rst_rgb",      int'(bus0.rgb_out), 0);
    chk("rst_p_tick",   int'(bus0.p_tick), 0);
    chk("rst_video_on", int'(bus0.video_on), 1);
    chk("rst_frame",    int'(bus0.frame_tick), 0);
    chk("rst_small_x",  int'(bus1.pixel_x), 0);
    rst0 = 1'b1;
    rst1 = 1'b1;

    for (int i = 0; i < 13; i++) begin
      wait_n0(tv[i].n);
      chk($sformatf("tv%0d_x", i),   int'(bus0.pixel_x),  tv[i].x);
      chk($sformatf("tv%0d_y", i),   int'(bus0.pixel_y),  tv[i].y);
      chk($sformatf("tv%0d_pt", i),  int'(bus0.p_tick),   tv[i].pt);
      chk($sformatf("tv%0d_von", i), int'(bus0.video_on), tv[i].von);
      chk($sformatf("tv%0d_hs", i),  int'(bus0.hsync),    tv[i].hs);
      chk($sformatf("tv%0d_vs", i),  int'(bus0.vsync),    tv[i].vs);
      chk($sformatf("tv%0d_rgb", i), int'(bus0.rgb_out),  tv[i].rgb);
    end

    wait_ft1(t1);
    @(negedge clk);
    wait_ft1(t2);
    chk("small_frame_period", t2 - t1, 196);

    lo = 0;
    pt = 0;
    for (int i = 0; i < 3200; i++) begin
      @(negedge clk);
      if (!bus0.hsync) lo++;
      if (bus0.p_tick) pt++;
    end
    chk("hsync_low_clks", lo, 384);
    chk("ticks_per_line", pt, 800);

    // Mid-line asynchronous reset on the default instance, inside hsync.
    wait_n0(9201);
    chk("pre_rst_x",     int'(bus0.pixel_x), 700);
    chk("pre_rst_hsync", int'(bus0.hsync), 0);
    #2 rst0 = 1'b0;
    #1;
    chk("async_rst_hsync", int'(bus0.hsync), 1);
    chk("async_rst_vsync", int'(bus0.vsync), 1);
    chk("async_rst_rgb",   int'(bus0.rgb_out), 0);
    chk("async_rst_x",     int'(bus0.pixel_x), 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    wait_n0(3);
    chk("rerelease_pt", int'(bus0.p_tick), 1);
    chk("rerelease_x3", int'(bus0.pixel_x), 0);
    wait_n0(4);
    chk("rerelease_x4", int'(bus0.pixel_x), 1);

    // Mid-frame asynchronous reset on the small instance, inside vsync and hsync.
    g = 0;
    while ((n1 % 196) != 161 && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("small_pre_rst_n", n1 % 196, 161);
    chk("small_pre_rst_x", int'(bus1.pixel_x), 10);
    chk("small_pre_rst_y", int'(bus1.pixel_y), 5);
    chk("small_pre_rst_vsync", int'(bus1.vsync), 0);
    chk("small_pre_rst_hsync", int'(bus1.hsync), 0);
    #2 rst1 = 1'b0;
    #1;
    chk("small_async_hsync", int'(bus1.hsync), 1);
    chk("small_async_vsync", int'(bus1.vsync), 1);
    chk("small_async_rgb",   int'(bus1.rgb_out), 0);
    chk("small_async_y",     int'(bus1.pixel_y), 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    chk("small_first_tick", int'(bus1.p_tick), 1);
    @(negedge clk);
    chk("small_x_after_tick", int'(bus1.pixel_x), 1);
    repeat (400) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
